// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit for the Execute stage.
// Owns the architectural HI/LO registers, computes the full result at start
// time, then holds it in a pending buffer until a fixed latency expires so
// the rest of the pipeline sees the same timing as an iterative unit.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDU_op,
   input  logic [31:0] E_rs_data,
   input  logic [31:0] E_rt_data,
   output logic        E_MDU_start,
   output logic        E_MDU_busy,
   output logic        E_MDU_stall_req,
   output logic [31:0] E_MDU_result,
   output logic [31:0] HI_out,
   output logic [31:0] LO_out
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } mduOp_e;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      r_pendHi;
   logic [31:0]      r_pendLo;
   logic             r_commit;
   logic             r_busy;
   logic [CNT_W-1:0] r_count;

   logic               w_isMul;
   logic               w_isMulDiv;
   logic               w_start;
   logic               w_rtZero;
   logic               w_sdivOvf;
   logic [31:0]        w_divisor;
   logic signed [63:0] w_sProd;
   logic [63:0]        w_uProd;
   logic signed [31:0] w_sQuot;
   logic signed [31:0] w_sRem;
   logic [31:0]        w_uQuot;
   logic [31:0]        w_uRem;
   logic [31:0]        w_resHi;
   logic [31:0]        w_resLo;
   logic               w_resCommit;

   // Classify the op; a new operation is only accepted while idle.
   always_comb begin
      w_isMul    = (E_MDU_op == OP_MULT) || (E_MDU_op == OP_MULTU);
      w_isMulDiv = w_isMul || (E_MDU_op == OP_DIV) || (E_MDU_op == OP_DIVU);
      w_start    = w_isMulDiv && !r_busy;
   end

   // Datapath arithmetic. The divisor is forced to 1 for divide-by-zero and
   // for the signed overflow case so the divider never sees an undefined
   // operation; those cases are resolved explicitly below.
   always_comb begin
      w_rtZero  = (E_rt_data == 32'd0);
      w_sdivOvf = (E_rs_data == 32'h8000_0000) && (E_rt_data == 32'hFFFF_FFFF);
      w_divisor = (w_rtZero || w_sdivOvf) ? 32'd1 : E_rt_data;
      w_sProd   = $signed(E_rs_data) * $signed(E_rt_data);
      w_uProd   = {32'd0, E_rs_data} * {32'd0, E_rt_data};
      w_sQuot   = $signed(E_rs_data) / $signed(w_divisor);
      w_sRem    = $signed(E_rs_data) % $signed(w_divisor);
      w_uQuot   = E_rs_data / w_divisor;
      w_uRem    = E_rs_data % w_divisor;
   end

   // Select the HI/LO pair to buffer, and whether it should ever be committed.
   always_comb begin
      w_resHi     = 32'd0;
      w_resLo     = 32'd0;
      w_resCommit = 1'b1;
      case (E_MDU_op)
         OP_MULT: begin
            w_resHi = w_sProd[63:32];
            w_resLo = w_sProd[31:0];
         end
         OP_MULTU: begin
            w_resHi = w_uProd[63:32];
            w_resLo = w_uProd[31:0];
         end
         OP_DIV: begin
            if (w_rtZero) begin
               w_resCommit = 1'b0;
            end else if (w_sdivOvf) begin
               w_resHi = 32'd0;
               w_resLo = 32'h8000_0000;
            end else begin
               w_resHi = w_sRem;
               w_resLo = w_sQuot;
            end
         end
         OP_DIVU: begin
            if (w_rtZero) begin
               w_resCommit = 1'b0;
            end else begin
               w_resHi = w_uRem;
               w_resLo = w_uQuot;
            end
         end
         default: begin
            w_resCommit = 1'b1;
         end
      endcase
   end

   // HI/LO, pending buffer and latency counter. While busy only the countdown
   // runs, so stray ops and mthi/mtlo cannot disturb an in-flight operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_pendHi <= 32'd0;
         r_pendLo <= 32'd0;
         r_commit <= 1'b0;
         r_busy   <= 1'b0;
         r_count  <= '0;
      end else if (r_busy) begin
         r_count <= r_count - CNT_W'(1);
         if (r_count == CNT_W'(1)) begin
            r_busy <= 1'b0;
            if (r_commit) begin
               r_hi <= r_pendHi;
               r_lo <= r_pendLo;
            end
         end
      end else if (w_start) begin
         r_pendHi <= w_resHi;
         r_pendLo <= w_resLo;
         r_commit <= w_resCommit;
         r_count  <= w_isMul ? MULT_LOAD : DIV_LOAD;
         r_busy   <= 1'b1;
      end else if (E_MDU_op == OP_MTHI) begin
         r_hi <= E_rs_data;
      end else if (E_MDU_op == OP_MTLO) begin
         r_lo <= E_rs_data;
      end
   end

   // Read port for mfhi/mflo and status outputs toward the hazard unit.
   always_comb begin
      E_MDU_result = 32'd0;
      if (E_MDU_op == OP_MFHI) begin
         E_MDU_result = r_hi;
      end else if (E_MDU_op == OP_MFLO) begin
         E_MDU_result = r_lo;
      end
      E_MDU_start     = w_start;
      E_MDU_busy      = r_busy;
      E_MDU_stall_req = w_start || r_busy;
      HI_out          = r_hi;
      LO_out          = r_lo;
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized self-checking bench for e_mdu. Expected HI/LO come
// from a 64-bit arithmetic model of mult/div semantics kept in the bench.
module tb_e_mdu;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  E_MDU_op;
   logic [31:0] E_rs_data;
   logic [31:0] E_rt_data;
   logic        E_MDU_start;
   logic        E_MDU_busy;
   logic        E_MDU_stall_req;
   logic [31:0] E_MDU_result;
   logic [31:0] HI_out;
   logic [31:0] LO_out;

   int total = 0;
   int bad   = 0;
   logic [31:0] expHi;
   logic [31:0] expLo;

   e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk),
      .reset(reset),
      .E_MDU_op(E_MDU_op),
      .E_rs_data(E_rs_data),
      .E_rt_data(E_rt_data),
      .E_MDU_start(E_MDU_start),
      .E_MDU_busy(E_MDU_busy),
      .E_MDU_stall_req(E_MDU_stall_req),
      .E_MDU_result(E_MDU_result),
      .HI_out(HI_out),
      .LO_out(LO_out)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Present one op on the falling edge and let combinational outputs settle.
   task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      @(negedge clk);
      E_MDU_op  = op;
      E_rs_data = rs;
      E_rt_data = rt;
      #1;
   endtask

   // Architectural effect of one accepted op on HI/LO, in 64-bit arithmetic.
   task automatic modelExec(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      logic signed [63:0] a;
      logic signed [63:0] b;
      logic signed [63:0] q;
      logic signed [63:0] r;
      logic [63:0] p;
      case (op)
         4'd1: begin
            a = {{32{rs[31]}}, rs};
            b = {{32{rt[31]}}, rt};
            p = a * b;
            expHi = p[63:32];
            expLo = p[31:0];
         end
         4'd2: begin
            p = {32'd0, rs} * {32'd0, rt};
            expHi = p[63:32];
            expLo = p[31:0];
         end
         4'd3, 4'd4: begin
            if (rt != 32'd0) begin
               if (op == 4'd3) begin
                  a = {{32{rs[31]}}, rs};
                  b = {{32{rt[31]}}, rt};
               end else begin
                  a = {32'd0, rs};
                  b = {32'd0, rt};
               end
               q = a / b;
               r = a - q * b;
               expLo = q[31:0];
               expHi = r[31:0];
            end
         end
         4'd7: expHi = rs;
         4'd8: expLo = rs;
         default: ;
      endcase
   endtask

   // Reset state: everything cleared, no start or stall
   task automatic test_reset();
      reset = 1'b1;
      drive(4'd5, 32'd0, 32'd0);
      drive(4'd5, 32'd0, 32'd0);
      total++;
      if ({E_MDU_busy, E_MDU_start, E_MDU_stall_req} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL reset_status got=%b exp=000", {E_MDU_busy, E_MDU_start, E_MDU_stall_req});
      end
      total++;
      if ({HI_out, LO_out, E_MDU_result} !== 96'd0) begin
         bad++;
         $display("[TB] FAIL reset_hilo got hi=%h lo=%h res=%h exp=0", HI_out, LO_out, E_MDU_result);
      end
      reset = 1'b0;
      expHi = 32'd0;
      expLo = 32'd0;
      drive(4'd0, 32'd0, 32'd0);
   endtask

   // One arithmetic op class: a directed vector then random vectors
   task automatic test_arith(input string name, input logic [3:0] op, input int cycles,
                             input logic [31:0] rs0, input logic [31:0] rt0, input int nRand);
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] oldHi;
      logic [31:0] oldLo;
      for (int v = 0; v <= nRand; v++) begin
         if (v == 0) begin
            rs = rs0;
            rt = rt0;
         end else begin
            rs = $urandom;
            rt = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rt = 32'd0;
         end
         oldHi = expHi;
         oldLo = expLo;
         drive(op, rs, rt);
         total++;
         if ({E_MDU_start, E_MDU_stall_req, E_MDU_busy} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL %s_start got=%b exp=110", name, {E_MDU_start, E_MDU_stall_req, E_MDU_busy});
         end
         modelExec(op, rs, rt);
         for (int i = 0; i < cycles; i++) begin
            drive(4'd0, $urandom, $urandom);
            total++;
            if ({E_MDU_busy, HI_out, LO_out} !== {1'b1, oldHi, oldLo}) begin
               bad++;
               $display("[TB] FAIL %s_busy_hold cyc=%0d got busy=%b hi=%h lo=%h exp busy=1 hi=%h lo=%h",
                        name, i, E_MDU_busy, HI_out, LO_out, oldHi, oldLo);
            end
         end
         drive(4'd5, 32'd0, 32'd0);
         total++;
         if ({E_MDU_busy, HI_out, LO_out, E_MDU_result} !== {1'b0, expHi, expLo, expHi}) begin
            bad++;
            $display("[TB] FAIL %s_result rs=%h rt=%h got busy=%b hi=%h lo=%h mfhi=%h exp busy=0 hi=%h lo=%h",
                     name, rs, rt, E_MDU_busy, HI_out, LO_out, E_MDU_result, expHi, expLo);
         end
         drive(4'd6, 32'd0, 32'd0);
         total++;
         if (E_MDU_result !== expLo) begin
            bad++;
            $display("[TB] FAIL %s_mflo got=%h exp=%h", name, E_MDU_result, expLo);
         end
      end
   endtask

   // Division by zero leaves HI/LO untouched after the full latency
   task automatic test_divzero();
      drive(4'd7, 32'h11, 32'd0);
      modelExec(4'd7, 32'h11, 32'd0);
      drive(4'd8, 32'h22, 32'd0);
      modelExec(4'd8, 32'h22, 32'd0);
      test_arith("divu0", 4'd4, DIV_N, 32'd7, 32'd0, 0);
      total++;
      if ({HI_out, LO_out} !== {32'h11, 32'h22}) begin
         bad++;
         $display("[TB] FAIL divzero_hilo got hi=%h lo=%h exp hi=11 lo=22", HI_out, LO_out);
      end
   endtask

   // mthi/mtlo when idle, ignored while busy; stray ops while busy ignored
   task automatic test_mthi_mtlo();
      logic [31:0] oldLo;
      oldLo = expLo;
      drive(4'd7, 32'hAAAA5555, 32'd0);
      modelExec(4'd7, 32'hAAAA5555, 32'd0);
      drive(4'd6, 32'd0, 32'd0);
      total++;
      if (E_MDU_result !== oldLo) begin
         bad++;
         $display("[TB] FAIL mthi_lo_kept got=%h exp=%h", E_MDU_result, oldLo);
      end
      drive(4'd5, 32'd0, 32'd0);
      total++;
      if ({E_MDU_result, HI_out} !== {32'hAAAA5555, 32'hAAAA5555}) begin
         bad++;
         $display("[TB] FAIL mthi_read got res=%h hi=%h exp=aaaa5555", E_MDU_result, HI_out);
      end
      drive(4'd8, 32'h12345678, 32'd0);
      modelExec(4'd8, 32'h12345678, 32'd0);
      drive(4'd6, 32'd0, 32'd0);
      total++;
      if (E_MDU_result !== 32'h12345678) begin
         bad++;
         $display("[TB] FAIL mtlo_read got=%h exp=12345678", E_MDU_result);
      end
      drive(4'd1, 32'd6, 32'd9);
      modelExec(4'd1, 32'd6, 32'd9);
      drive(4'd8, 32'hDEADBEEF, 32'd0);
      total++;
      if (LO_out !== 32'h12345678) begin
         bad++;
         $display("[TB] FAIL mtlo_busy got=%h exp=12345678", LO_out);
      end
      drive(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      total++;
      if ({E_MDU_start, E_MDU_stall_req} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL op_while_busy got=%b exp=01", {E_MDU_start, E_MDU_stall_req});
      end
      for (int i = 0; i < MULT_N - 2; i++) drive(4'd0, 32'd0, 32'd0);
      drive(4'd6, 32'd0, 32'd0);
      total++;
      if ({E_MDU_busy, E_MDU_result, HI_out} !== {1'b0, 32'd54, 32'd0}) begin
         bad++;
         $display("[TB] FAIL mult_after_ignored got busy=%b lo=%h hi=%h exp busy=0 lo=36 hi=0",
                  E_MDU_busy, E_MDU_result, HI_out);
      end
      drive(4'd12, 32'h5, 32'h5);
      total++;
      if ({E_MDU_result, E_MDU_start, E_MDU_stall_req} !== {32'd0, 2'b00}) begin
         bad++;
         $display("[TB] FAIL op12_none got res=%h start=%b stall=%b exp 0", E_MDU_result, E_MDU_start, E_MDU_stall_req);
      end
   endtask

   // Reset during a divide aborts it with no late commit
   task automatic test_reset_mid_div();
      drive(4'd3, 32'hFFFFFFF9, 32'd2);
      drive(4'd0, 32'd0, 32'd0);
      drive(4'd0, 32'd0, 32'd0);
      drive(4'd0, 32'd0, 32'd0);
      total++;
      if (E_MDU_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rstdiv_busy_before got=%b exp=1", E_MDU_busy);
      end
      reset = 1'b1;
      drive(4'd0, 32'd0, 32'd0);
      reset = 1'b0;
      expHi = 32'd0;
      expLo = 32'd0;
      total++;
      if ({E_MDU_busy, HI_out, LO_out} !== 65'd0) begin
         bad++;
         $display("[TB] FAIL rstdiv_cleared got busy=%b hi=%h lo=%h exp 0", E_MDU_busy, HI_out, LO_out);
      end
      for (int i = 0; i < DIV_N + 2; i++) begin
         drive(4'd0, 32'd0, 32'd0);
         total++;
         if ({E_MDU_busy, HI_out, LO_out} !== 65'd0) begin
            bad++;
            $display("[TB] FAIL rstdiv_no_commit cyc=%0d got busy=%b hi=%h lo=%h exp 0", i, E_MDU_busy, HI_out, LO_out);
         end
      end
   endtask

   // Second mult issued on the first idle cycle; stall never drops
   task automatic test_back_to_back();
      logic [31:0] rsA;
      logic [31:0] rtA;
      logic [31:0] rsB;
      logic [31:0] rtB;
      logic [31:0] aHi;
      logic [31:0] aLo;
      rsA = $urandom;
      rtA = $urandom;
      rsB = $urandom;
      rtB = $urandom;
      drive(4'd1, rsA, rtA);
      modelExec(4'd1, rsA, rtA);
      aHi = expHi;
      aLo = expLo;
      for (int i = 0; i < MULT_N; i++) begin
         drive(4'd0, 32'd0, 32'd0);
         total++;
         if ({E_MDU_stall_req, E_MDU_busy} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL b2b_first_busy cyc=%0d got=%b exp=11", i, {E_MDU_stall_req, E_MDU_busy});
         end
      end
      drive(4'd1, rsB, rtB);
      total++;
      if ({E_MDU_start, E_MDU_stall_req, E_MDU_busy, HI_out, LO_out} !== {3'b110, aHi, aLo}) begin
         bad++;
         $display("[TB] FAIL b2b_second_start got start=%b stall=%b busy=%b hi=%h lo=%h exp 110 hi=%h lo=%h",
                  E_MDU_start, E_MDU_stall_req, E_MDU_busy, HI_out, LO_out, aHi, aLo);
      end
      modelExec(4'd2 - 4'd1, rsB, rtB);
      for (int i = 0; i < MULT_N; i++) begin
         drive(4'd0, 32'd0, 32'd0);
         total++;
         if ({E_MDU_stall_req, HI_out, LO_out} !== {1'b1, aHi, aLo}) begin
            bad++;
            $display("[TB] FAIL b2b_second_busy cyc=%0d got stall=%b hi=%h lo=%h exp stall=1 hi=%h lo=%h",
                     i, E_MDU_stall_req, HI_out, LO_out, aHi, aLo);
         end
      end
      drive(4'd0, 32'd0, 32'd0);
      total++;
      if ({E_MDU_stall_req, E_MDU_busy, HI_out, LO_out} !== {2'b00, expHi, expLo}) begin
         bad++;
         $display("[TB] FAIL b2b_second_result got stall=%b busy=%b hi=%h lo=%h exp 00 hi=%h lo=%h",
                  E_MDU_stall_req, E_MDU_busy, HI_out, LO_out, expHi, expLo);
      end
   endtask

   // Test sequence
   initial begin
      reset     = 1'b1;
      E_MDU_op  = 4'd0;
      E_rs_data = 32'd0;
      E_rt_data = 32'd0;
      expHi     = 32'd0;
      expLo     = 32'd0;
      test_reset();
      test_arith("mult",  4'd1, MULT_N, 32'hFFFFFFFD, 32'd7, 4);
      total++;
      if ({HI_out, LO_out} !== 64'd0 && expHi === 32'hFFFFFFFF && HI_out !== expHi) begin
         bad++;
         $display("[TB] FAIL mult_model_hi got=%h exp=%h", HI_out, expHi);
      end
      test_arith("multu", 4'd2, MULT_N, 32'hFFFFFFFF, 32'd2, 4);
      test_arith("div",   4'd3, DIV_N, 32'hFFFFFFF9, 32'd2, 4);
      test_arith("divovf", 4'd3, DIV_N, 32'h80000000, 32'hFFFFFFFF, 0);
      total++;
      if ({HI_out, LO_out} !== {32'h0, 32'h80000000}) begin
         bad++;
         $display("[TB] FAIL divovf_const got hi=%h lo=%h exp hi=0 lo=80000000", HI_out, LO_out);
      end
      test_arith("divu",  4'd4, DIV_N, 32'hFFFFFFF9, 32'd2, 4);
      test_divzero();
      test_mthi_mtlo();
      test_reset_mid_div();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the Execute stage, directly downstream of the D/E pipeline register.
- Consumes the decoded MDU operation and the forwarded rs/rt operands of the instruction currently in E.
- Owns the architectural HI/LO registers and serves mfhi/mflo reads to the E result mux.
- Exposes a busy/stall request so the hazard unit can freeze D while an MDU operation is pending.

Parameters:
- MULT_CYCLES, 5, number of cycles busy stays high after a mult/multu start.
- DIV_CYCLES, 10, number of cycles busy stays high after a div/divu start.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- E_MDU_op  input  4  decoded op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 treated as none.
- E_rs_data  input  32  forwarded rs operand.
- E_rt_data  input  32  forwarded rt operand.
- E_MDU_start  output  1  high when E_MDU_op is 1-4 and busy is low (combinational).
- E_MDU_busy  output  1  registered; high while an operation is in flight.
- E_MDU_stall_req  output  1  E_MDU_start | E_MDU_busy; the hazard unit stalls D on any MDU-class instruction while this is high.
- E_MDU_result  output  32  HI when op=5, LO when op=6, else 0 (combinational from the registers).
- HI_out  output  32  current HI register.
- LO_out  output  32  current LO register.

Behaviour:
- Reset (clk edge with reset=1): HI=0, LO=0, busy=0, counter=0, pending results=0. A reset mid-operation aborts the operation; no HI/LO commit occurs.
- Start: at the edge where E_MDU_start=1, latch the full result into pending_hi/pending_lo (combinational compute from the operands of that cycle), load counter=MULT_CYCLES or DIV_CYCLES, and set busy=1.
- Busy phase: counter decrements by 1 on each edge while busy. On the edge where counter goes 1->0, busy drops to 0 and HI/LO take pending_hi/pending_lo in that same edge.
- Resulting timing: busy is high for exactly N cycles after the start edge. An mfhi/mflo in E on the first cycle with busy=0 reads the new values.
- Arithmetic:
  - mult: signed 32x32->64; HI=upper, LO=lower.
  - multu: unsigned 32x32->64.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned.
- Divide by zero (rt=0, div or divu): the op still starts and busy runs for DIV_CYCLES, but at completion HI/LO are left unchanged.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: write rs into HI/LO at the next edge, only when busy=0.
  - If busy=1 they are ignored; the hazard unit must make this unreachable.
  - mthi/mtlo while busy=0 takes effect immediately.
- Op values 1-4 while busy=1: E_MDU_start=0, the op is ignored, and the in-flight op is unaffected. The stall logic guarantees this never happens legitimately.
- Flush/bubble arrives as op=0, which is a no-op and does not disturb an in-flight operation.
- E_MDU_result while busy: returns the stale HI/LO. The hazard unit stalls mfhi/mflo in D, so this is never consumed.

Test Plan:
- mult rs=0xFFFFFFFD (-3), rt=7 -> start=1 for 1 cycle; busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; mfhi returns 0xFFFFFFFF.
- multu rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; HI/LO hold old values every cycle busy is high.
- div rs=0xFFFFFFF9 (-7), rt=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with HI=0x11, LO=0x22 beforehand -> HI/LO still 0x11/0x22 after 10 cycles.
- mthi 0xAAAA5555 then mflo/mfhi next cycle -> HI=0xAAAA5555, LO unchanged. mtlo presented while busy=1 -> LO unchanged.
- Assert reset at cycle 3 of a div -> busy=0, HI=LO=0 on the following cycle; no late commit.
- Back-to-back: mult presented again on the cycle busy drops -> second start accepted, stall_req=1 continuously, HI/LO show the first result then the second.
